// File: rtl/cluster_sequencer.sv
// rtl/cluster_sequencer.sv - iterative cluster extractor around an external pad priority encoder
// Optional watchdog: define CLUSTER_SEQ_WATCHDOG_EN.
module cluster_sequencer #(
    parameter int MXPADS      = 1536,
    parameter int MXADRBITS   = 11,
    parameter int MXCLUSTERS  = 8,
    parameter int ENC_LAT     = 1,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                          clock,
    input  logic                          global_reset_n,
    input  logic                          frame_start,
    input  logic [MXPADS-1:0]             vpfs,
    input  logic [MXPADS*3-1:0]           cnts,
    output logic [MXPADS-1:0]             enc_vpfs,
    output logic [MXPADS*3-1:0]           enc_cnts,
    input  logic [MXADRBITS-1:0]          enc_adr,
    input  logic [2:0]                    enc_cnt,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MXADRBITS-1:0]          out_adr,
    output logic [2:0]                    out_cnt,
    output logic [$clog2(MXCLUSTERS)-1:0] out_idx,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          frame_drop,
    output logic                          timeout
);

    localparam int IDXW = $clog2(MXCLUSTERS);
    localparam int NCW  = IDXW + 1;
    localparam int LATW = (ENC_LAT < 1) ? 1 : $clog2(ENC_LAT + 1);
    localparam logic [MXADRBITS-1:0] NO_HIT = MXADRBITS'('h7FE);
    localparam logic [MXADRBITS-1:0] PADS_A = MXADRBITS'(MXPADS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [MXPADS-1:0]      mask_q, mask_d;
    logic [MXPADS*3-1:0]    cnts_q, cnts_d;
    logic [LATW-1:0]        lat_q, lat_d;
    logic [NCW-1:0]         n_clu_q, n_clu_d;
    logic [MXADRBITS-1:0]   adr_q, adr_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   hit_ok;

`ifdef CLUSTER_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           tmo_q, tmo_d;
`endif

    // Out-of-range addresses end the frame just like the explicit no-hit code.
    assign hit_ok = (enc_adr != NO_HIT) && (enc_adr < PADS_A);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnts_d  = cnts_q;
        lat_d   = (lat_q != '0) ? lat_q - 1'b1 : lat_q;
        n_clu_d = n_clu_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef CLUSTER_SEQ_WATCHDOG_EN
        tmo_d   = tmo_q;
        wd_d    = (state_q != S_IDLE) ? wd_q + 1'b1 : wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    mask_d  = vpfs;
                    cnts_d  = cnts;
                    lat_d   = LATW'(ENC_LAT);
                    n_clu_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_SEARCH;
`ifdef CLUSTER_SEQ_WATCHDOG_EN
                    tmo_d   = 1'b0;
                    wd_d    = WDW'(1);
`endif
                end
            end
            S_SEARCH: begin
                // Encoder output only reflects the current mask once lat_q drains.
                if (lat_q == '0) begin
                    if (!hit_ok) begin
                        ovf_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        adr_d           = enc_adr;
                        cnt_d           = enc_cnt;
                        mask_d[enc_adr] = 1'b0;
                        lat_d           = LATW'(ENC_LAT);
                        state_d         = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    n_clu_d = n_clu_q + 1'b1;
                    if (n_clu_q == NCW'(MXCLUSTERS - 1)) begin
                        ovf_d   = |mask_q;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEARCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef CLUSTER_SEQ_WATCHDOG_EN
        if ((state_q == S_SEARCH || state_q == S_EMIT) && wd_q == WDW'(WDOG_CYCLES - 1)) begin
            state_d = S_DONE;
            ovf_d   = 1'b0;
            tmo_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            cnts_q  <= '0;
            lat_q   <= '0;
            n_clu_q <= '0;
            adr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef CLUSTER_SEQ_WATCHDOG_EN
            wd_q    <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnts_q  <= cnts_d;
            lat_q   <= lat_d;
            n_clu_q <= n_clu_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef CLUSTER_SEQ_WATCHDOG_EN
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign enc_vpfs   = mask_q;
    assign enc_cnts   = cnts_q;
    assign out_valid  = (state_q == S_EMIT);
    assign out_adr    = adr_q;
    assign out_cnt    = cnt_q;
    assign out_idx    = n_clu_q[IDXW-1:0];
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign overflow   = frame_done & ovf_q;
    assign frame_drop = frame_start & busy;
`ifdef CLUSTER_SEQ_WATCHDOG_EN
    assign timeout    = frame_done & tmo_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_cluster_sequencer.sv
// tb/tb_cluster_sequencer.sv - randomized self-checking bench for cluster_sequencer
module tb_cluster_sequencer;

    localparam int MXPADS = 1536;
    localparam int MXADRBITS = 11;
    localparam int MXCLUSTERS = 8;
`ifdef CLUSTER_SEQ_WATCHDOG_EN
    localparam int WD = 16;
`else
    localparam int WD = 64;
`endif

    logic                      clock = 1'b0;
    logic                      global_reset_n = 1'b0;
    logic                      frame_start = 1'b0;
    logic [MXPADS-1:0]         vpfs = '0;
    logic [MXPADS*3-1:0]       cnts = '0;
    logic [MXPADS-1:0]         enc_vpfs;
    logic [MXPADS*3-1:0]       enc_cnts;
    logic [MXADRBITS-1:0]      enc_adr = 11'h7FE;
    logic [2:0]                enc_cnt = 3'd0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [MXADRBITS-1:0]      out_adr;
    logic [2:0]                out_cnt;
    logic [2:0]                out_idx;
    logic                      busy, frame_done, overflow, frame_drop, timeout;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    cluster_sequencer #(
        .MXPADS(MXPADS), .MXADRBITS(MXADRBITS), .MXCLUSTERS(MXCLUSTERS),
        .ENC_LAT(1), .WDOG_CYCLES(WD)
    ) dut (
        .clock(clock), .global_reset_n(global_reset_n), .frame_start(frame_start),
        .vpfs(vpfs), .cnts(cnts), .enc_vpfs(enc_vpfs), .enc_cnts(enc_cnts),
        .enc_adr(enc_adr), .enc_cnt(enc_cnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_adr(out_adr), .out_cnt(out_cnt), .out_idx(out_idx), .busy(busy),
        .frame_done(frame_done), .overflow(overflow), .frame_drop(frame_drop), .timeout(timeout)
    );

    // External encoder: lowest set pad wins, one clock of latency.
    always @(posedge clock) begin
        logic [MXADRBITS-1:0] a;
        logic [2:0]           c;
        a = 11'h7FE;
        c = 3'd0;
        for (int i = MXPADS - 1; i >= 0; i--) begin
            if (enc_vpfs[i]) begin
                a = MXADRBITS'(i);
                c = enc_cnts[3*i +: 3];
            end
        end
        enc_adr <= a;
        enc_cnt <= c;
    end

    function automatic logic [MXPADS*3-1:0] rand_cnts();
        logic [MXPADS*3-1:0] c;
        for (int i = 0; i < MXPADS; i++) c[3*i +: 3] = 3'($urandom_range(0, 7));
        return c;
    endfunction

    task automatic run_frame(input string name, input logic [MXPADS-1:0] v,
                             input logic [MXPADS*3-1:0] c, input int ready_pct,
                             input int stall_n, input int drop_at);
        int exp_adr[$];
        int exp_cnt[$];
        int got_adr[$];
        int got_cnt[$];
        int got_idx[$];
        int got_cyc[$];
        bit exp_ovf;
        bit got_ovf;
        bit done;
        bit held;
        bit rdy;
        logic [17:0] held_word;
        int cyc;
        int stalls;
        int done_cyc;
        int n;
        int exp_done;

        exp_ovf = 1'b0;
        for (int i = 0; i < MXPADS; i++) begin
            if (v[i]) begin
                if (exp_adr.size() < MXCLUSTERS) begin
                    exp_adr.push_back(i);
                    exp_cnt.push_back(int'(c[3*i +: 3]));
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end

        @(negedge clock);
        vpfs = v;
        cnts = c;
        frame_start = 1'b1;
        @(posedge clock);
        #1 frame_start = 1'b0;
        cyc = 0; done = 0; held = 0; stalls = 0; done_cyc = -1; got_ovf = 0;
        held_word = '0;
        while (!done && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (held) begin
                n_checks++;
                if ({out_valid, out_adr, out_cnt, out_idx} !== held_word)
                    $display("FAIL %s stall_hold cyc=%0d got=%h want=%h", name, cyc,
                             {out_valid, out_adr, out_cnt, out_idx}, held_word);
                else n_pass++;
            end
            rdy = 1'b0;
            if (out_valid) begin
                if (stalls >= stall_n) rdy = ($urandom_range(0, 99) < ready_pct);
                if (!rdy) stalls++;
            end
            out_ready = rdy;
            if (out_valid && rdy) begin
                got_adr.push_back(int'(out_adr));
                got_cnt.push_back(int'(out_cnt));
                got_idx.push_back(int'(out_idx));
                got_cyc.push_back(cyc);
            end
            held = out_valid && !rdy;
            held_word = {out_valid, out_adr, out_cnt, out_idx};
            if (frame_done) begin
                done = 1;
                done_cyc = cyc;
                got_ovf = overflow;
                n_checks++;
                if (timeout !== 1'b0) $display("FAIL %s timeout got=%b want=0", name, timeout);
                else n_pass++;
                if (drop_at >= 0) begin
                    frame_start = 1'b1;
                    #1;
                    n_checks++;
                    if (frame_drop !== 1'b1) $display("FAIL %s drop_in_done got=%b want=1", name, frame_drop);
                    else n_pass++;
                    @(posedge clock);
                    #1 frame_start = 1'b0;
                    @(negedge clock);
                    n_checks++;
                    if (busy !== 1'b0) $display("FAIL %s busy_after_drop got=%b want=0", name, busy);
                    else n_pass++;
                end
            end else if (cyc == drop_at) begin
                frame_start = 1'b1;
                #1;
                n_checks++;
                if (frame_drop !== 1'b1) $display("FAIL %s frame_drop got=%b want=1", name, frame_drop);
                else n_pass++;
                @(posedge clock);
                #1 frame_start = 1'b0;
            end
        end
        out_ready = 1'b0;

        n_checks++;
        if (!done) $display("FAIL %s frame_done_wait got=none want=pulse", name);
        else n_pass++;
        n_checks++;
        if (got_adr.size() != exp_adr.size())
            $display("FAIL %s cluster_count got=%0d want=%0d", name, got_adr.size(), exp_adr.size());
        else n_pass++;
        n = (got_adr.size() < exp_adr.size()) ? got_adr.size() : exp_adr.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (got_adr[i] != exp_adr[i] || got_cnt[i] != exp_cnt[i] || got_idx[i] != i)
                $display("FAIL %s cluster%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", name, i,
                         got_adr[i], got_cnt[i], got_idx[i], exp_adr[i], exp_cnt[i], i);
            else n_pass++;
            if (ready_pct == 100) begin
                n_checks++;
                if (got_cyc[i] != 3 + 2 * i + stall_n)
                    $display("FAIL %s cluster%0d_cycle got=%0d want=%0d", name, i, got_cyc[i], 3 + 2 * i + stall_n);
                else n_pass++;
            end
        end
        n_checks++;
        if (got_ovf !== exp_ovf) $display("FAIL %s overflow got=%b want=%b", name, got_ovf, exp_ovf);
        else n_pass++;
        if (ready_pct == 100) begin
            exp_done = ((exp_adr.size() == MXCLUSTERS) ? 2 * MXCLUSTERS + 2 : 2 * exp_adr.size() + 3) + stall_n;
            n_checks++;
            if (done_cyc != exp_done) $display("FAIL %s done_cycle got=%0d want=%0d", name, done_cyc, exp_done);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        global_reset_n = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if ((|enc_vpfs) || (|enc_cnts) || out_valid || (|out_adr) || (|out_cnt) || (|out_idx) ||
            busy || frame_done || overflow || frame_drop || timeout)
            $display("FAIL reset_outputs got=nonzero adr=%0d valid=%b busy=%b want=0", out_adr, out_valid, busy);
        else n_pass++;
        global_reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy got=%b want=0", busy);
        else n_pass++;
    endtask

    task automatic test_fixed();
        logic [MXPADS-1:0] v;
        v = '0;
        v[5] = 1'b1; v[700] = 1'b1; v[1535] = 1'b1;
        run_frame("fixed3", v, rand_cnts(), 100, 0, -1);
    endtask

    task automatic test_empty();
        run_frame("empty", '0, rand_cnts(), 100, 0, -1);
    endtask

    task automatic test_overflow();
        logic [MXPADS-1:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) v[i] = 1'b1;
        run_frame("overflow", v, rand_cnts(), 100, 0, -1);
        v = '0;
        for (int i = 0; i < 8; i++) v[100 + 3 * i] = 1'b1;
        run_frame("exact8", v, rand_cnts(), 100, 0, -1);
    endtask

    task automatic test_stall();
        logic [MXPADS-1:0]   v;
        logic [MXPADS*3-1:0] c;
        v = '0;
        v[42] = 1'b1;
        c = rand_cnts();
        c[3*42 +: 3] = 3'd5;
        run_frame("stall", v, c, 100, 10, -1);
    endtask

    task automatic test_drop();
        logic [MXPADS-1:0] v;
        v = '0;
        v[5] = 1'b1; v[700] = 1'b1; v[1535] = 1'b1;
        run_frame("drop", v, rand_cnts(), 100, 0, 2);
    endtask

    task automatic test_random();
        logic [MXPADS-1:0] v;
        int nh;
        for (int f = 0; f < 8; f++) begin
            v = '0;
            nh = $urandom_range(0, 12);
            for (int k = 0; k < nh; k++) v[$urandom_range(0, MXPADS - 1)] = 1'b1;
            run_frame("random", v, rand_cnts(), (f % 2 == 0) ? 100 : 60, 0, -1);
        end
    endtask

    task automatic test_midreset();
        logic [MXPADS-1:0] v;
        v = '0;
        v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1;
        @(negedge clock);
        vpfs = v;
        cnts = rand_cnts();
        frame_start = 1'b1;
        @(posedge clock);
        #1 frame_start = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clock);
        global_reset_n = 1'b0;
        #1;
        n_checks++;
        if ((|enc_vpfs) || (|enc_cnts) || out_valid || (|out_adr) || (|out_cnt) || (|out_idx) ||
            busy || frame_done || overflow || timeout)
            $display("FAIL midreset_outputs adr=%0d valid=%b busy=%b done=%b want=0", out_adr, out_valid, busy, frame_done);
        else n_pass++;
        @(negedge clock);
        global_reset_n = 1'b1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            n_checks++;
            if (busy || frame_done) $display("FAIL midreset_idle busy=%b done=%b want=0", busy, frame_done);
            else n_pass++;
        end
    endtask

`ifdef CLUSTER_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        logic [MXPADS-1:0] v;
        int cyc;
        v = '0;
        v[3] = 1'b1;
        @(negedge clock);
        vpfs = v;
        frame_start = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        #1 frame_start = 1'b0;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (frame_done) break;
        end
        n_checks++;
        if (cyc != WD) $display("FAIL wdog_cycle got=%0d want=%0d", cyc, WD);
        else n_pass++;
        n_checks++;
        if ({frame_done, timeout, overflow, out_valid} !== 4'b1100)
            $display("FAIL wdog_flags got=%b want=1100", {frame_done, timeout, overflow, out_valid});
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_fixed();
        test_empty();
        test_stall();
        test_drop();
`ifdef CLUSTER_SEQ_WATCHDOG_EN
        test_watchdog();
`else
        test_overflow();
        test_random();
`endif
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cluster_sequencer.md
# cluster_sequencer

Iterative cluster extractor wrapped around the 1536-pad priority encoder. Latches one frame of pad hits (valid-pattern flags plus 3-bit counts), drives the masked hit vector into an external encoder instance, and captures each encoder result. After every capture it clears the winning pad and re-searches, emitting up to `MXCLUSTERS` clusters per frame in ascending pad order on a valid/ready stream. It sits between the pad-finding logic and the cluster packer/serializer.

## Interface
- `MXPADS`, 1536, pad count; encoder width.
- `MXADRBITS`, 11, address width.
- `MXCLUSTERS`, 8, maximum clusters emitted per frame.
- `ENC_LAT`, 1, encoder latency in clocks from `enc_vpfs`/`enc_cnts` change to valid `enc_adr`/`enc_cnt`.
- `WDOG_CYCLES`, 64, watchdog limit. Used only with `CLUSTER_SEQ_WATCHDOG_EN`.
- `clock`, in, 1, single clock; all logic is rising-edge.
- `global_reset_n`, in, 1, asynchronous active-low reset.
- `frame_start`, in, 1, single-cycle load strobe.
- `vpfs`, in, MXPADS, pad valid flags, sampled on `frame_start`.
- `cnts`, in, MXPADS*3, pad counts, sampled on `frame_start`.
- `enc_vpfs`, out, MXPADS, masked hit vector to the encoder.
- `enc_cnts`, out, MXPADS*3, latched counts to the encoder.
- `enc_adr`, in, 11, encoder address; 11'h7FE means no hit.
- `enc_cnt`, in, 3, encoder count for `enc_adr`.
- `out_valid`, out, 1, cluster word valid.
- `out_ready`, in, 1, downstream accept.
- `out_adr`, out, 11, cluster pad address.
- `out_cnt`, out, 3, cluster count.
- `out_idx`, out, 3 (clog2 MXCLUSTERS), cluster index within the frame, starting at 0.
- `busy`, out, 1, high whenever the FSM is not in IDLE.
- `frame_done`, out, 1, one-cycle pulse at end of frame.
- `overflow`, out, 1, qualifies `frame_done`: hits remained after `MXCLUSTERS` clusters were emitted.
- `frame_drop`, out, 1, one-cycle pulse when `frame_start` arrives while `busy`.
- `timeout`, out, 1, qualifies `frame_done`: frame ended by the watchdog.

## Operation
- State: `mask[MXPADS-1:0]` drives `enc_vpfs` directly. The `cnts` latch drives `enc_cnts`.
- `lat_cnt` is a down-counter. It reloads to `ENC_LAT` on every write of `mask` and decrements to 0 otherwise.
- `n_clu` is the count of clusters emitted in the current frame.
- FSM states: IDLE, SEARCH, EMIT, DONE.
- **IDLE**
  - On `frame_start`: load `mask`←`vpfs`, latch `cnts`, clear `n_clu`, go to SEARCH.
- **SEARCH**
  - Wait while `lat_cnt`≠0.
  - At `lat_cnt`==0, if `enc_adr`==11'h7FE: go to DONE with `overflow`=0.
  - Otherwise: register `enc_adr`/`enc_cnt` into `out_adr`/`out_cnt`, clear `mask[enc_adr]`, go to EMIT.
- **EMIT**
  - `out_valid`=1. `out_adr`, `out_cnt` and `out_idx`=`n_clu` are held stable until accepted.
  - On `out_valid`&&`out_ready`: increment `n_clu`.
  - If the new `n_clu`==`MXCLUSTERS`: go to DONE with `overflow`=|`mask`.
  - Else: go to SEARCH.
- **DONE**
  - Pulse `frame_done` for one cycle with `overflow`/`timeout` valid, then go to IDLE.
  - `mask` is not cleared.
- `frame_start` in any state other than IDLE: ignored, `frame_drop` pulses. The same-cycle `frame_start` in the DONE cycle is also dropped.
- Addresses ≥ `MXPADS` other than 11'h7FE are treated as no-hit (end of frame).

## Timing
- Reset values: every output is 0, including `enc_vpfs`, `enc_cnts`, `out_*`, `busy` and the status pulses. `mask`=0, FSM=IDLE.
- Asserting `global_reset_n` low mid-frame aborts immediately. No `frame_done` is issued.
- `frame_start` at cycle 0 → `enc_vpfs` valid at cycle 1, `busy`=1 at cycle 1.
- First capture at cycle 1+`ENC_LAT`; first `out_valid` at cycle 2+`ENC_LAT` (cycle 3 for the default).
- With `out_ready` held high, subsequent clusters follow every `ENC_LAT`+1 cycles (every 2 cycles for the default).
- Empty frame: `frame_done` at cycle 2+`ENC_LAT`.
- Stalls: `out_ready` low holds EMIT indefinitely. The outputs must not change while `out_valid`&&!`out_ready`.

## Configuration
- `CLUSTER_SEQ_WATCHDOG_EN` defined:
  - A cycle counter starts at `frame_start` accept.
  - On reaching `WDOG_CYCLES` in SEARCH or EMIT, the FSM forces DONE with `timeout`=1 and drops `out_valid`.
  - `overflow` is 0 on a timeout frame.
- Not defined: no counter is built, `timeout` is tied to 0, and EMIT may stall forever.

## Test plan
- Hits at pads 5, 700, 1535; `out_ready`=1 → clusters (5,idx0), (700,idx1), (1535,idx2) at cycles 3, 5, 7; `frame_done` at cycle 9 with `overflow`=0.
- All-zero `vpfs` → no `out_valid`; `frame_done` at cycle 3 with `overflow`=0.
- Hits on pads 0–9 → exactly 8 clusters, pads 0–7, idx 0–7; `frame_done` with `overflow`=1.
- Hit at pad 42 with cnt 5; `out_ready` low for 10 cycles → `out_adr`=42 and `out_cnt`=5 held stable throughout; accepted on the first ready cycle.
- `frame_start` at cycle 2 of a busy frame → `frame_drop` pulses at cycle 2 and the original frame completes unchanged. Separately, `global_reset_n` low at cycle 4 → all outputs 0 at once and FSM=IDLE.
- With `CLUSTER_SEQ_WATCHDOG_EN`, `WDOG_CYCLES`=16, `out_ready` stuck at 0 → `frame_done`=1 with `timeout`=1 at cycle 16 after accept, and `out_valid` drops.
